// File: rtl/fp_regfile_wb.sv
// Floating-point register file $f0-$f31 with a one-entry writeback stage.
// Staged writes are forwarded to both read ports; the FPU result has priority over mtc1.
module fp_regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] fs_addr,
  input  logic [ADDR_W-1:0] ft_addr,
  output logic [DATA_W-1:0] data1,
  output logic [DATA_W-1:0] data2,
  input  logic              fpu_we,
  input  logic [ADDR_W-1:0] fpu_waddr,
  input  logic [DATA_W-1:0] fpu_wdata,
  input  logic              mtc1_valid,
  input  logic [ADDR_W-1:0] mtc1_addr,
  input  logic [DATA_W-1:0] mtc1_data,
  output logic              mtc1_ready
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              r_stage_valid;
  logic [ADDR_W-1:0] r_stage_addr;
  logic [DATA_W-1:0] r_stage_data;

  logic              w_mtc1_accept;
  logic              w_hit1;
  logic              w_hit2;

  assign mtc1_ready    = rst_n & ~fpu_we;
  assign w_mtc1_accept = mtc1_valid & mtc1_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the whole array is reset because software may read any register
      // before writing it; this keeps the array in flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
      r_stage_valid <= 1'b0;
      r_stage_addr  <= '0;
      r_stage_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments let commit read the old stage contents
      // while capture overwrites them on the same edge.
      if (r_stage_valid) begin
        r_regs[r_stage_addr] <= r_stage_data;
      end
      if (fpu_we) begin
        r_stage_valid <= 1'b1;
        r_stage_addr  <= fpu_waddr;
        r_stage_data  <= fpu_wdata;
      end else if (w_mtc1_accept) begin
        r_stage_valid <= 1'b1;
        r_stage_addr  <= mtc1_addr;
        r_stage_data  <= mtc1_data;
      end else begin
        r_stage_valid <= 1'b0;
      end
    end
  end

  // The stage holds the newest value for its address, so it wins over the array.
  assign w_hit1 = r_stage_valid && (r_stage_addr == fs_addr);
  assign w_hit2 = r_stage_valid && (r_stage_addr == ft_addr);
  assign data1  = w_hit1 ? r_stage_data : r_regs[fs_addr];
  assign data2  = w_hit2 ? r_stage_data : r_regs[ft_addr];

endmodule

// File: tb/tb_fp_regfile_wb.sv
// Self-checking bench for fp_regfile_wb: expected read data is queued when each
// cycle's stimulus is driven and popped when the read ports are sampled.
module tb_fp_regfile_wb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  fs_addr;
  logic [4:0]  ft_addr;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        fpu_we;
  logic [4:0]  fpu_waddr;
  logic [31:0] fpu_wdata;
  logic        mtc1_valid;
  logic [4:0]  mtc1_addr;
  logic [31:0] mtc1_data;
  logic        mtc1_ready;

  typedef struct {
    string       tag;
    logic [31:0] e1;
    logic [31:0] e2;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_pass;
  int   n_total;

  fp_regfile_wb #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fs_addr    (fs_addr),
    .ft_addr    (ft_addr),
    .data1      (data1),
    .data2      (data2),
    .fpu_we     (fpu_we),
    .fpu_waddr  (fpu_waddr),
    .fpu_wdata  (fpu_wdata),
    .mtc1_valid (mtc1_valid),
    .mtc1_addr  (mtc1_addr),
    .mtc1_data  (mtc1_data),
    .mtc1_ready (mtc1_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs change just after the rising edge, outputs are sampled
  // on the falling edge once the combinational reads have settled.
  task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic mv, input logic [4:0] ma,
                       input logic [31:0] md, input logic [4:0] fs, input logic [4:0] ft);
    @(posedge clk);
    #1;
    rst_n      = rst;
    fpu_we     = we;
    fpu_waddr  = wa;
    fpu_wdata  = wd;
    mtc1_valid = mv;
    mtc1_addr  = ma;
    mtc1_data  = md;
    fs_addr    = fs;
    ft_addr    = ft;
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234_5678, 5'd0, 5'd0);
      n_total++;
      if (mtc1_ready !== 1'b0)
        $display("FAIL reset_ready cycle %0d got %b want 0", c, mtc1_ready);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      sb.push_back('{$sformatf("reset_f%0d", i), 32'h0, 32'h0});
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  task automatic test_mtc1;
    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 32'h42C8_0000, 5'd0, 5'd0);
    sb.push_back('{"mtc1_c0", 32'h0, 32'h0});
    n_total++;
    if (mtc1_ready !== 1'b1) $display("FAIL mtc1_ready_c0 got %b want 1", mtc1_ready);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
    else n_pass++;

    drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h41C8_0000, 5'd1, 5'd2);
    sb.push_back('{"mtc1_c1", 32'h42C8_0000, 32'h0});
    n_total++;
    if (mtc1_ready !== 1'b1) $display("FAIL mtc1_ready_c1 got %b want 1", mtc1_ready);
    else n_pass++;
    e = sb.pop_front();
    n_total++;
    if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
    else n_pass++;
    n_total++;
    if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
    else n_pass++;

    for (int c = 2; c < 4; c++) begin
      drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
      sb.push_back('{$sformatf("mtc1_c%0d", c), 32'h42C8_0000, 32'h41C8_0000});
      n_total++;
      if (mtc1_ready !== 1'b1) $display("FAIL mtc1_ready_c%0d got %b want 1", c, mtc1_ready);
      else n_pass++;
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  task automatic test_bypass;
    logic [4:0]  ft_tab [4] = '{5'd1, 5'd3, 5'd2, 5'd3};
    logic [31:0] e1_tab [4] = '{32'h0, 32'h42FA_0000, 32'h42FA_0000, 32'h42FA_0000};
    logic [31:0] e2_tab [4] = '{32'h42C8_0000, 32'h42FA_0000, 32'h41C8_0000, 32'h42FA_0000};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, c == 0, 5'd3, 32'h42FA_0000, 1'b0, 5'd0, 32'h0, 5'd3, ft_tab[c]);
      sb.push_back('{$sformatf("bypass_c%0d", c), e1_tab[c], e2_tab[c]});
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  task automatic test_priority;
    logic        we_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        mv_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic        rd_tab [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  ft_tab [4] = '{5'd4, 5'd3, 5'd4, 5'd4};
    logic [31:0] e1_tab [4] = '{32'h0, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    logic [31:0] e2_tab [4] = '{32'h0, 32'h42FA_0000, 32'h3F80_0000, 32'h3F80_0000};
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, we_tab[c], 5'd4, 32'h4000_0000, mv_tab[c], 5'd4, 32'h3F80_0000,
            5'd4, ft_tab[c]);
      sb.push_back('{$sformatf("prio_c%0d", c), e1_tab[c], e2_tab[c]});
      n_total++;
      if (mtc1_ready !== rd_tab[c])
        $display("FAIL prio_ready_c%0d got %b want %b", c, mtc1_ready, rd_tab[c]);
      else n_pass++;
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    logic        we_tab [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] wd_tab [5] = '{32'hC1B8_0000, 32'hC5AF_F000, 32'h0, 32'h0, 32'h0};
    logic [4:0]  ft_tab [5] = '{5'd5, 5'd4, 5'd5, 5'd5, 5'd5};
    logic [31:0] e1_tab [5] = '{32'h0, 32'hC1B8_0000, 32'hC5AF_F000, 32'hC5AF_F000,
                                32'hC5AF_F000};
    logic [31:0] e2_tab [5] = '{32'h0, 32'h3F80_0000, 32'hC5AF_F000, 32'hC5AF_F000,
                                32'hC5AF_F000};
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, we_tab[c], 5'd5, wd_tab[c], 1'b0, 5'd0, 32'h0, 5'd5, ft_tab[c]);
      sb.push_back('{$sformatf("b2b_c%0d", c), e1_tab[c], e2_tab[c]});
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  task automatic test_reset_discard;
    logic        rst_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        we_tab  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic [4:0]  ft_tab  [4] = '{5'd1, 5'd1, 5'd1, 5'd5};
    logic [31:0] e1_tab  [4] = '{32'h0, 32'h44AD_A000, 32'h0, 32'h0};
    logic [31:0] e2_tab  [4] = '{32'h42C8_0000, 32'h42C8_0000, 32'h0, 32'h0};
    for (int c = 0; c < 4; c++) begin
      drive(rst_tab[c], we_tab[c], 5'd6, 32'h44AD_A000, 1'b0, 5'd0, 32'h0, 5'd6, ft_tab[c]);
      sb.push_back('{$sformatf("rstdisc_c%0d", c), e1_tab[c], e2_tab[c]});
      n_total++;
      if (mtc1_ready !== (rst_tab[c] & ~we_tab[c]))
        $display("FAIL rstdisc_ready_c%0d got %b want %b", c, mtc1_ready,
                 rst_tab[c] & ~we_tab[c]);
      else n_pass++;
      e = sb.pop_front();
      n_total++;
      if (data1 !== e.e1) $display("FAIL %s data1 got %h want %h", e.tag, data1, e.e1);
      else n_pass++;
      n_total++;
      if (data2 !== e.e2) $display("FAIL %s data2 got %h want %h", e.tag, data2, e.e2);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass     = 0;
    n_total    = 0;
    rst_n      = 1'b0;
    fpu_we     = 1'b0;
    fpu_waddr  = '0;
    fpu_wdata  = '0;
    mtc1_valid = 1'b0;
    mtc1_addr  = '0;
    mtc1_data  = '0;
    fs_addr    = '0;
    ft_addr    = '0;
    test_reset();
    test_mtc1();
    test_bypass();
    test_priority();
    test_back_to_back();
    test_reset_discard();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
